// File: rtl/axis_multichannel_sync_repeater.sv
// axis_multichannel_sync_repeater: per-channel sample bank replayed as one AXI-stream burst per sync.
// Define SYNC_REPEATER_SKIP_STALE_EN to skip channels not written since the previous snapshot.
module axis_multichannel_sync_repeater #(
    parameter int DATA_WIDTH = 32,
    parameter int DEST_WIDTH = 8,
    parameter int USER_WIDTH = 8,
    parameter int N_CHANNELS = 4,
    parameter int DEST_BASE  = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  sync,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [DEST_WIDTH-1:0] in_dest,
    input  logic [USER_WIDTH-1:0] in_user,
    input  logic                  in_tlast,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [DEST_WIDTH-1:0] out_dest,
    output logic [USER_WIDTH-1:0] out_user,
    output logic                  out_tlast,
    output logic                  sync_overrun,
    output logic                  dest_error
);
    localparam int W  = DATA_WIDTH + USER_WIDTH;
    localparam int CW = N_CHANNELS > 1 ? $clog2(N_CHANNELS) : 1;

    typedef enum logic {IDLE, EMIT} state_t;
    state_t state, state_nxt;

    logic [W-1:0]          bank [N_CHANNELS];
    logic [W-1:0]          snap [N_CHANNELS];
    logic [DEST_WIDTH:0]   offset;
    logic                  in_range, wr, take, last, unused;
    logic [CW-1:0]         wr_idx, cur;
    logic [N_CHANNELS-1:0] wr_oh;

    assign in_ready = reset;
    assign unused   = in_tlast;
    // Extra MSB catches dests below DEST_BASE as a negative offset
    assign offset   = {1'b0, in_dest} - (DEST_WIDTH+1)'(DEST_BASE);
    assign in_range = !offset[DEST_WIDTH] && offset < (DEST_WIDTH+1)'(N_CHANNELS);
    assign wr       = in_valid && in_range;
    assign wr_idx   = offset[CW-1:0];
    assign take     = state == EMIT && out_ready;

    always_comb begin
        wr_oh = '0;
        if (wr) wr_oh[wr_idx] = 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_CHANNELS; i++) begin
                bank[i] <= '0;
                snap[i] <= '0;
            end
            sync_overrun <= 1'b0;
            dest_error   <= 1'b0;
        end else begin
            if (wr) bank[wr_idx] <= {in_data, in_user};
            if (state == IDLE && sync)
                for (int i = 0; i < N_CHANNELS; i++)
                    snap[i] <= wr_oh[i] ? {in_data, in_user} : bank[i];
            sync_overrun <= sync && state == EMIT;
            dest_error   <= in_valid && !in_range;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else state <= state_nxt;
    end

`ifdef SYNC_REPEATER_SKIP_STALE_EN
    logic [N_CHANNELS-1:0] fresh, pending, rest;

    // pending holds the channels of the current burst still to be emitted
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fresh   <= '0;
            pending <= '0;
        end else if (state == IDLE && sync) begin
            fresh   <= wr_oh;
            pending <= fresh | wr_oh;
        end else begin
            fresh <= fresh | wr_oh;
            if (take) pending <= rest;
        end
    end

    always_comb begin
        cur = '0;
        for (int i = N_CHANNELS - 1; i >= 0; i--)
            if (pending[i]) cur = CW'(i);
        rest = pending;
        rest[cur] = 1'b0;
        last = rest == '0;
        state_nxt = state;
        if (state == IDLE && sync && (fresh | wr_oh) != '0) state_nxt = EMIT;
        if (take && last) state_nxt = IDLE;
    end
`else
    logic [CW-1:0] ch;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) ch <= '0;
        else if (state == IDLE && sync) ch <= '0;
        else if (take && !last) ch <= ch + 1'b1;
    end

    always_comb begin
        cur = ch;
        last = ch == CW'(N_CHANNELS - 1);
        state_nxt = state;
        if (state == IDLE && sync) state_nxt = EMIT;
        if (take && last) state_nxt = IDLE;
    end
`endif

    assign out_valid            = state == EMIT;
    assign {out_data, out_user} = out_valid ? snap[cur] : '0;
    assign out_dest             = out_valid ? DEST_WIDTH'(DEST_BASE) + DEST_WIDTH'(cur) : '0;
    assign out_tlast            = out_valid && last;
endmodule
